// File: rtl/patch_stream_arbiter_pkg.sv
// Shared definitions for the patch stream arbiter and its round-robin picker.
//   log2()       : ceil(log2(value)), never less than 1; sizes index and counter fields
//   eof_marker() : all-ones value of a given width, used as the end-of-frame patch number
//   TRUE/FALSE   : single-bit constants
//   arb_state_e  : arbiter states RUN=0, BARRIER=1, EOF_OUT=2, ERROR=3
package patch_stream_arbiter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BARRIER = 2'd1,
        ST_EOF_OUT = 2'd2,
        ST_ERROR   = 2'd3
    } arb_state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int unsigned log2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'd1 << w) < 64'(value))) begin
            w = w + 1;
        end
        return w;
    endfunction

    // All-ones pattern of width w; the caller sizes it with an explicit cast.
    function automatic logic [31:0] eof_marker(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/patch_stream_arbiter_rr_grant.sv
// Round-robin priority picker: grants the first requester at or after ptr, wrapping at N.
// Pure combinational; shared with the bandwidth arbiter.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant, zero when nothing requests
//   gnt_idx : index of the granted requester (0 when none)
//   gnt_val : a grant was issued
module patch_stream_arbiter_rr_grant
    import patch_stream_arbiter_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = log2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_val
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_val = FALSE;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!gnt_val && req[IW'(idx)]) begin
                gnt[IW'(idx)] = TRUE;
                gnt_idx       = IW'(idx);
                gnt_val       = TRUE;
            end
        end
    end

endmodule

// File: rtl/patch_stream_arbiter.sv
// Round-robin arbiter sharing the synchronizer patch write port among N_CAM camera
// streams, with a sync window against the retire pointer and an end-of-frame barrier.
// Optional build macro: PATCH_SEQ_CHECK_EN enables patch-number sequence checking.
//   CLK, RESET     : clock, synchronous active-high reset
//   cam_val        : per-camera patch valid
//   cam_ack        : per-camera accept (combinational, one-hot or zero)
//   cam_patch_num  : flattened patch numbers, camera i at [i*PATCH_W +: PATCH_W]
//   cam_wtsum      : flattened payloads, camera i at [i*FP_SIZE +: FP_SIZE]
//   wr_val         : registered write valid to the synchronizer
//   wr_ready       : synchronizer takes wr_* this cycle
//   wr_cam         : source camera of the held word
//   wr_patch_num   : patch number, all-ones for the end-of-frame word
//   wr_wtsum       : payload
//   retire         : synchronizer finished one patch index
//   error          : sticky protocol error
//   busy           : barrier or end-of-frame emission in progress
module patch_stream_arbiter
    import patch_stream_arbiter_pkg::*;
#(
    parameter int unsigned N_CAM       = 3,
    parameter int unsigned N_PATCH     = 1024,
    parameter int unsigned SYNC_WINDOW = 512,
    parameter int unsigned FP_SIZE     = 32,
    parameter int unsigned PATCH_W     = log2(N_PATCH + 1)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [N_CAM-1:0]            cam_val,
    output logic [N_CAM-1:0]            cam_ack,
    input  logic [N_CAM*PATCH_W-1:0]    cam_patch_num,
    input  logic [N_CAM*FP_SIZE-1:0]    cam_wtsum,
    output logic                        wr_val,
    input  logic                        wr_ready,
    output logic [log2(N_CAM)-1:0]      wr_cam,
    output logic [PATCH_W-1:0]          wr_patch_num,
    output logic [FP_SIZE-1:0]          wr_wtsum,
    input  logic                        retire,
    output logic                        error,
    output logic                        busy
);

    localparam int unsigned          CAM_W    = log2(N_CAM);
    localparam logic [PATCH_W-1:0]   EOF_MARK = PATCH_W'(eof_marker(PATCH_W));
    localparam logic [PATCH_W-1:0]   WINDOW   = PATCH_W'(SYNC_WINDOW);

    arb_state_e          state;
    logic [PATCH_W-1:0]  next_cnt [N_CAM];
    logic [PATCH_W-1:0]  ret_cnt;
    logic [N_CAM-1:0]    eof_seen;
    logic [CAM_W-1:0]    rr_ptr;

    logic [PATCH_W-1:0]  pn [N_CAM];
    logic [FP_SIZE-1:0]  ws [N_CAM];
    logic [N_CAM-1:0]    is_eof;
    logic [N_CAM-1:0]    elig;
    logic [N_CAM-1:0]    req;
    logic [CAM_W-1:0]    gnt_idx;
    logic                gnt_val;
    logic                out_free;
    logic                arb_en;
    logic                ret_hit;
    logic                retire_err;
    logic                seq_err;
    logic                g_eof;
    logic [PATCH_W-1:0]  g_pn;
    logic [FP_SIZE-1:0]  g_ws;

    // Unpack camera lanes and form eligibility; distances wrap modulo 2**PATCH_W.
    for (genvar i = 0; i < N_CAM; i++) begin : g_cam
        assign pn[i]     = cam_patch_num[i*PATCH_W +: PATCH_W];
        assign ws[i]     = cam_wtsum[i*FP_SIZE +: FP_SIZE];
        assign is_eof[i] = (pn[i] == EOF_MARK);
        assign elig[i]   = cam_val[i] & ~eof_seen[i]
                         & (is_eof[i] | ((next_cnt[i] - ret_cnt) < WINDOW));
    end

    // Retire would overtake the slowest camera when ret already equals some next[i].
    always_comb begin
        ret_hit = FALSE;
        for (int unsigned i = 0; i < N_CAM; i++) begin
            if (next_cnt[i] == ret_cnt) begin
                ret_hit = TRUE;
            end
        end
    end

    assign out_free   = ~wr_val | wr_ready;
    assign retire_err = retire & (ret_hit | (state == ST_EOF_OUT));
    // A cycle that trips a retire error grants nothing, so no word is consumed and lost.
    assign arb_en     = ~RESET & ~retire_err & ((state == ST_RUN) | (state == ST_BARRIER));
    assign req        = (arb_en & out_free) ? elig : '0;

    patch_stream_arbiter_rr_grant #(
        .N  (N_CAM),
        .IW (CAM_W)
    ) u_rr_grant (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (cam_ack),
        .gnt_idx (gnt_idx),
        .gnt_val (gnt_val)
    );

    assign g_eof = is_eof[gnt_idx];
    assign g_pn  = pn[gnt_idx];
    assign g_ws  = ws[gnt_idx];

`ifdef PATCH_SEQ_CHECK_EN
    // Data must arrive in order; EOF only after exactly N_PATCH patches.
    assign seq_err = gnt_val & (g_eof ? (next_cnt[gnt_idx] != PATCH_W'(N_PATCH))
                                      : (g_pn != next_cnt[gnt_idx]));
`else
    assign seq_err = FALSE;
`endif

    // Arbitration state, counters and the registered write-side word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_RUN;
            wr_val       <= FALSE;
            wr_cam       <= '0;
            wr_patch_num <= '0;
            wr_wtsum     <= '0;
            error        <= FALSE;
            busy         <= FALSE;
            ret_cnt      <= '0;
            eof_seen     <= '0;
            rr_ptr       <= '0;
            for (int unsigned i = 0; i < N_CAM; i++) begin
                next_cnt[i] <= '0;
            end
        end else begin
            case (state)
                ST_RUN, ST_BARRIER: begin
                    if (retire_err || seq_err) begin
                        state <= ST_ERROR;
                        error <= TRUE;
                        busy  <= FALSE;
                        if (out_free) begin
                            wr_val <= FALSE;
                        end
                    end else begin
                        if (retire) begin
                            ret_cnt <= ret_cnt + PATCH_W'(1);
                        end
                        if (out_free) begin
                            wr_val <= FALSE;
                        end
                        if (gnt_val) begin
                            rr_ptr <= (gnt_idx == CAM_W'(N_CAM - 1)) ? '0 : gnt_idx + CAM_W'(1);
                            if (g_eof) begin
                                // EOF is held back until every camera has reported it.
                                eof_seen[gnt_idx] <= TRUE;
                            end else begin
                                next_cnt[gnt_idx] <= next_cnt[gnt_idx] + PATCH_W'(1);
                                wr_val            <= TRUE;
                                wr_cam            <= gnt_idx;
                                wr_patch_num      <= g_pn;
                                wr_wtsum          <= g_ws;
                            end
                        end
                        if (state == ST_RUN) begin
                            if ((gnt_val & g_eof) | (|eof_seen)) begin
                                state <= ST_BARRIER;
                                busy  <= TRUE;
                            end
                        end else if ((&eof_seen) & out_free) begin
                            state <= ST_EOF_OUT;
                        end
                    end
                end

                ST_EOF_OUT: begin
                    if (retire) begin
                        state <= ST_ERROR;
                        error <= TRUE;
                        busy  <= FALSE;
                        if (out_free) begin
                            wr_val <= FALSE;
                        end
                    end else if (out_free) begin
                        // Emit the single frame marker and start the next frame from zero.
                        wr_val       <= TRUE;
                        wr_cam       <= '0;
                        wr_patch_num <= EOF_MARK;
                        wr_wtsum     <= '0;
                        eof_seen     <= '0;
                        ret_cnt      <= '0;
                        for (int unsigned i = 0; i < N_CAM; i++) begin
                            next_cnt[i] <= '0;
                        end
                        state        <= ST_RUN;
                        busy         <= FALSE;
                    end
                end

                ST_ERROR: begin
                    // Let the pending word drain, then stay idle until reset.
                    if (wr_ready) begin
                        wr_val <= FALSE;
                    end
                end

                default: begin
                    state <= ST_ERROR;
                    error <= TRUE;
                end
            endcase
        end
    end

endmodule
